// File: rtl/param_add_pipe_if.sv
// Handshake bundle for param_add_pipe.
//   in_valid/in_ready/in_data     : word-set input, lane k at [k*WIDTH +: WIDTH]
//   out_valid/out_ready/out_data  : word-set output, same packing
//   out_ovf                       : per-lane overflow flag, aligned with out_data
// master = producer/consumer side (bench, regression top); slave = the adder.
interface param_add_pipe_if #(
  parameter int WIDTH = 32,
  parameter int LANES = 1
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_data;
  logic [LANES-1:0]       out_ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/param_add_pipe.sv
// param_add_pipe: multi-lane pipelined offset adder.
// Each lane adds OFFSET to the low 2*N bits of its word (wrap or saturate),
// result leaves STAGES cycles later. Elastic valid/ready pipeline, running
// 64-bit checksum and transfer counter over delivered outputs.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   bus (slave)  : in_valid/in_ready/in_data, out_valid/out_ready/out_data/out_ovf
//   chk_clear    : synchronous checksum clear (wins over an update)
//   chk          : running checksum of transferred outputs
//   xfer_cnt     : number of output transfers, wraps at 2^32

// One lane of stage-1 arithmetic (purely combinational).
module param_add_lane #(
  parameter int               WIDTH = 32,
  parameter int               N     = 16,
  parameter logic [WIDTH-1:0] OFF   = '0,
  parameter bit               SAT   = 1'b0
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] res,
  output logic             ovf
);
  // Keeps bits [2*N-1:0]; shift form avoids a zero-width replicate when 2*N == WIDTH.
  localparam logic [WIDTH-1:0] MASK = {WIDTH{1'b1}} >> (WIDTH - 2*N);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, din & MASK} + {1'b0, OFF};
  assign ovf = sum[WIDTH];
  assign res = (SAT && ovf) ? '1 : sum[WIDTH-1:0];
endmodule

module param_add_pipe #(
  parameter int              WIDTH    = 32,
  parameter int              N        = 16,
  parameter longint unsigned OFFSET   = 1,
  parameter int              STAGES   = 2,
  parameter int              LANES    = 1,
  parameter int              SATURATE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  param_add_pipe_if.slave      bus,
  input  logic                 chk_clear,
  output logic [63:0]          chk,
  output logic [31:0]          xfer_cnt
);
  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("param_add_pipe: WIDTH must be 2..64");
  end
  if (N < 1 || 2*N > WIDTH) begin : g_bad_n
    $error("param_add_pipe: need 1 <= N and 2*N <= WIDTH");
  end
  if (STAGES < 1 || LANES < 1) begin : g_bad_depth
    $error("param_add_pipe: STAGES and LANES must be >= 1");
  end

  localparam logic [WIDTH-1:0] OFF = WIDTH'(OFFSET);

  logic [LANES-1:0][WIDTH-1:0]             lane_res;
  logic [LANES-1:0]                        lane_ovf;
  logic [STAGES:1]                         vld_pipe;
  logic [STAGES:1][LANES-1:0][WIDTH-1:0]   dat_pipe;
  logic [STAGES:1][LANES-1:0]              ovf_pipe;
  logic [STAGES+1:1]                       rdy;      // rdy[s]: stage s may load this cycle
  logic                                    xfer;
  logic [63:0]                             fold;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    param_add_lane #(
      .WIDTH (WIDTH),
      .N     (N),
      .OFF   (OFF),
      .SAT   (SATURATE != 0)
    ) u_lane (
      .din (bus.in_data[k*WIDTH +: WIDTH]),
      .res (lane_res[k]),
      .ovf (lane_ovf[k])
    );
  end

  // Ready ripples back from the consumer: a stage loads when it is empty or
  // its occupant moves on. This makes in_ready combinational from out_ready.
  always_comb begin
    logic r;
    rdy = '0;
    r   = bus.out_ready;
    rdy[STAGES+1] = r;
    for (int s = STAGES; s >= 1; s--) begin
      r      = !vld_pipe[s] || r;
      rdy[s] = r;
    end
  end

  assign bus.in_ready  = !reset && rdy[1];
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.out_data  = dat_pipe[STAGES];
  assign bus.out_ovf   = ovf_pipe[STAGES];
  assign xfer          = vld_pipe[STAGES] && bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
      ovf_pipe <= '0;
    end else begin
      if (rdy[1]) begin
        vld_pipe[1] <= bus.in_valid;
        if (bus.in_valid) begin
          dat_pipe[1] <= lane_res;
          ovf_pipe[1] <= lane_ovf;
        end
      end
      for (int s = 2; s <= STAGES; s++) begin
        if (rdy[s]) begin
          vld_pipe[s] <= vld_pipe[s-1];
          // Bubbles do not overwrite payload, so out_data only moves with real items.
          if (vld_pipe[s-1]) begin
            dat_pipe[s] <= dat_pipe[s-1];
            ovf_pipe[s] <= ovf_pipe[s-1];
          end
        end
      end
    end
  end

  always_comb begin
    fold = '0;
    for (int k = 0; k < LANES; k++) fold = fold ^ 64'(dat_pipe[STAGES][k]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chk      <= '0;
      xfer_cnt <= '0;
    end else begin
      if (xfer) xfer_cnt <= xfer_cnt + 32'd1;
      if (chk_clear)  chk <= '0;
      else if (xfer)  chk <= fold ^ {chk[62:0], chk[63] ^ chk[2] ^ chk[0]};
    end
  end
endmodule

// File: tb/tb_param_add_pipe.sv
// Bench for param_add_pipe: two configurations side by side.
//   A: WIDTH=32 N=16 OFFSET=2 STAGES=2 LANES=2 wrap
//   B: WIDTH=16 N=4  OFFSET=0x1FFF0 (truncates to 0xFFF0) STAGES=3 LANES=3 saturate
// Per-DUT monitors compare every output transfer, the checksum and the
// transfer count against an arithmetic reference model; directed steps check
// reset, latency, backpressure, checksum clear and mid-flight reset.
module tb_param_add_pipe;
  localparam int              A_W = 32, A_N = 16, A_ST = 2, A_L = 2, A_SAT = 0;
  localparam longint unsigned A_OFF = 64'd2;
  localparam int              B_W = 16, B_N = 4, B_ST = 3, B_L = 3, B_SAT = 1;
  localparam longint unsigned B_OFF = 64'h1FFF0;

  typedef struct packed { logic [63:0] d; logic [2:0] o; } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        clr_a, clr_b;
  logic [63:0] chk_a, chk_b;
  logic [31:0] cnt_a, cnt_b;

  param_add_pipe_if #(.WIDTH(A_W), .LANES(A_L)) ifa ();
  param_add_pipe_if #(.WIDTH(B_W), .LANES(B_L)) ifb ();

  param_add_pipe #(.WIDTH(A_W), .N(A_N), .OFFSET(A_OFF), .STAGES(A_ST),
                   .LANES(A_L), .SATURATE(A_SAT)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa), .chk_clear(clr_a), .chk(chk_a), .xfer_cnt(cnt_a));

  param_add_pipe #(.WIDTH(B_W), .N(B_N), .OFFSET(B_OFF), .STAGES(B_ST),
                   .LANES(B_L), .SATURATE(B_SAT)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb), .chk_clear(clr_b), .chk(chk_b), .xfer_cnt(cnt_b));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: per lane, take the low 2n bits, add offset mod 2^wd, detect carry out.
  function automatic exp_t ref_set(input logic [63:0] din, input int lanes, input int wd,
                                   input int n, input longint unsigned off, input bit sat);
    exp_t e;
    longint unsigned m, w, s, r;
    bit ovf;
    e = '0;
    m = 64'd1 << wd;
    for (int k = 0; k < lanes; k++) begin
      w   = (din >> (k*wd)) % m;
      s   = (w % (64'd1 << (2*n))) + (off % m);
      ovf = (s >= m);
      r   = (sat && ovf) ? m - 64'd1 : s % m;
      e.d = e.d | (r << (k*wd));
      e.o[k] = ovf;
    end
    return e;
  endfunction

  function automatic logic [63:0] lane_xor(input exp_t e, input int lanes, input int wd);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < lanes; k++) r = r ^ ((e.d >> (k*wd)) & ((64'd1 << wd) - 64'd1));
    return r;
  endfunction

  function automatic logic [63:0] chk_next(input logic [63:0] c, input logic [63:0] r);
    return r ^ {c[62:0], c[63] ^ c[2] ^ c[0]};
  endfunction

  bit          mon_en = 1'b0;
  exp_t        qa[$], qb[$];
  exp_t        ea, eb;
  logic [63:0] chk_ma, chk_mb, hd_a, hd_b;
  logic [31:0] cnt_ma, cnt_mb;
  bit          held_a, held_b;

  // Monitors sample mid-cycle: handshakes seen here complete at the next posedge.
  always @(negedge clk) if (mon_en) begin
    if (reset) begin
      qa.delete(); chk_ma = '0; cnt_ma = '0; held_a = 1'b0;
    end else begin
      check("a_chk", chk_a, chk_ma);
      check("a_xfer_cnt", 64'(cnt_a), 64'(cnt_ma));
      if (held_a) begin
        check("a_hold_valid", 64'(ifa.out_valid), 64'd1);
        check("a_hold_data", 64'(ifa.out_data), hd_a);
      end
      held_a = ifa.out_valid && !ifa.out_ready;
      hd_a   = 64'(ifa.out_data);
      if (ifa.out_valid && ifa.out_ready) begin
        check("a_out_expected", 64'(qa.size() > 0), 64'd1);
        if (qa.size() > 0) begin
          ea = qa.pop_front();
          check("a_out_data", 64'(ifa.out_data), ea.d);
          check("a_out_ovf", 64'(ifa.out_ovf), 64'(ea.o));
          cnt_ma = cnt_ma + 32'd1;
          chk_ma = chk_next(chk_ma, lane_xor(ea, A_L, A_W));
        end
      end
      if (clr_a) chk_ma = '0;
      if (ifa.in_valid && ifa.in_ready)
        qa.push_back(ref_set(64'(ifa.in_data), A_L, A_W, A_N, A_OFF, A_SAT != 0));
    end
  end

  always @(negedge clk) if (mon_en) begin
    if (reset) begin
      qb.delete(); chk_mb = '0; cnt_mb = '0; held_b = 1'b0;
    end else begin
      check("b_chk", chk_b, chk_mb);
      check("b_xfer_cnt", 64'(cnt_b), 64'(cnt_mb));
      if (held_b) begin
        check("b_hold_valid", 64'(ifb.out_valid), 64'd1);
        check("b_hold_data", 64'(ifb.out_data), hd_b);
      end
      held_b = ifb.out_valid && !ifb.out_ready;
      hd_b   = 64'(ifb.out_data);
      if (ifb.out_valid && ifb.out_ready) begin
        check("b_out_expected", 64'(qb.size() > 0), 64'd1);
        if (qb.size() > 0) begin
          eb = qb.pop_front();
          check("b_out_data", 64'(ifb.out_data), eb.d);
          check("b_out_ovf", 64'(ifb.out_ovf), 64'(eb.o));
          cnt_mb = cnt_mb + 32'd1;
          chk_mb = chk_next(chk_mb, lane_xor(eb, B_L, B_W));
        end
      end
      if (clr_b) chk_mb = '0;
      if (ifb.in_valid && ifb.in_ready)
        qb.push_back(ref_set(64'(ifb.in_data), B_L, B_W, B_N, B_OFF, B_SAT != 0));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base;
    int sent;

    reset = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.out_ready = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_a_out_valid", 64'(ifa.out_valid), 64'd0);
    check("rst_a_in_ready", 64'(ifa.in_ready), 64'd0);
    check("rst_a_out_data", 64'(ifa.out_data), 64'd0);
    check("rst_a_out_ovf", 64'(ifa.out_ovf), 64'd0);
    check("rst_a_chk", chk_a, 64'd0);
    check("rst_a_xfer_cnt", 64'(cnt_a), 64'd0);
    check("rst_b_out_valid", 64'(ifb.out_valid), 64'd0);
    mon_en = 1'b1;
    reset = 1'b0;
    #1;
    check("rel_a_in_ready", 64'(ifa.in_ready), 64'd1);
    check("rel_b_in_ready", 64'(ifb.in_ready), 64'd1);

    // Latency, wrap (A) and saturate / offset truncation / slice (B)
    ifa.out_ready = 1'b1; ifb.out_ready = 1'b1;
    ifa.in_valid = 1'b1; ifa.in_data = {32'h7FFFFFFF, 32'hFFFFFFFF};
    ifb.in_valid = 1'b1; ifb.in_data = {16'hAB10, 16'h1205, 16'h770F};
    tick();
    ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
    check("lat_a_not_yet", 64'(ifa.out_valid), 64'd0);
    tick();
    check("lat_a_valid", 64'(ifa.out_valid), 64'd1);
    check("wrap_a_data", 64'(ifa.out_data), 64'h80000001_00000001);
    check("wrap_a_ovf", 64'(ifa.out_ovf), 64'd1);
    check("lat_b_not_yet", 64'(ifb.out_valid), 64'd0);
    tick();
    check("lat_b_valid", 64'(ifb.out_valid), 64'd1);
    check("sat_b_data", 64'(ifb.out_data), 64'h0000_FFFF_FFF5_FFFF);
    check("sat_b_ovf", 64'(ifb.out_ovf), 64'd4);
    tick(); tick();

    // Checksum from a cleared state: results 3 then 5 (other lane wraps to 0)
    clr_a = 1'b1; tick(); clr_a = 1'b0;
    check("chk_cleared", chk_a, 64'd0);
    base = cnt_ma;
    ifa.in_valid = 1'b1; ifa.in_data = {32'hFFFFFFFE, 32'd1}; tick();
    ifa.in_data = {32'hFFFFFFFE, 32'd3}; tick();
    ifa.in_valid = 1'b0; tick();
    check("chk_first", chk_a, 64'h3);
    tick();
    check("chk_second", chk_a, 64'h2);
    check("chk_cnt", 64'(cnt_a), 64'(base + 32'd2));

    // chk_clear coinciding with a transfer
    base = cnt_ma;
    ifa.in_valid = 1'b1; ifa.in_data = {32'hFFFFFFFE, 32'd5}; tick();
    ifa.in_valid = 1'b0; tick();
    clr_a = 1'b1; tick(); clr_a = 1'b0;
    check("clr_xfer_chk", chk_a, 64'd0);
    check("clr_xfer_cnt", 64'(cnt_a), 64'(base + 32'd1));

    // Backpressure: 8 sets, consumer stalled on cycles 3..7
    base = cnt_ma; sent = 0;
    for (int c = 0; c < 20; c++) begin
      ifa.in_valid  = (sent < 8);
      ifa.in_data   = {32'(sent + 100), 32'(sent)};
      ifa.out_ready = !(c >= 3 && c <= 7);
      #1;
      if (c >= 3 && c <= 7) check("bp_in_ready_low", 64'(ifa.in_ready), 64'd0);
      else if (c <= 8)      check("bp_in_ready_high", 64'(ifa.in_ready), 64'd1);
      if (c == 8) check("bp_full_out_valid", 64'(ifa.out_valid), 64'd1);
      if (ifa.in_valid && ifa.in_ready) sent++;
      tick();
    end
    ifa.in_valid = 1'b0;
    check("bp_sent", 64'(sent), 64'd8);
    check("bp_cnt", 64'(cnt_a), 64'(base + 32'd8));
    check("bp_drained", 64'(qa.size()), 64'd0);

    // Randomized traffic on both configurations
    for (int c = 0; c < 600; c++) begin
      ifa.in_valid  = 1'($urandom_range(0, 1));
      ifa.in_data   = ($urandom_range(0, 7) == 0) ? {32'h7FFFFFFF, 32'hFFFFFFFE}
                                                  : {$urandom(), $urandom()};
      ifa.out_ready = ($urandom_range(0, 3) != 0);
      clr_a         = ($urandom_range(0, 19) == 0);
      ifb.in_valid  = 1'($urandom_range(0, 1));
      ifb.in_data   = ($urandom_range(0, 7) == 0) ? 48'h0000_000F_0010
                                                  : {$urandom(), 16'($urandom())};
      ifb.out_ready = ($urandom_range(0, 2) != 0);
      clr_b         = ($urandom_range(0, 19) == 0);
      tick();
    end
    ifa.in_valid = 1'b0; ifb.in_valid = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    ifa.out_ready = 1'b1; ifb.out_ready = 1'b1;
    for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) tick();
    check("rand_a_drained", 64'(qa.size()), 64'd0);
    check("rand_b_drained", 64'(qb.size()), 64'd0);

    // Reset with two sets in flight
    ifa.out_ready = 1'b0;
    ifa.in_valid = 1'b1; ifa.in_data = {32'd10, 32'd11}; tick();
    ifa.in_data = {32'd12, 32'd13}; tick();
    ifa.in_valid = 1'b0;
    check("mid_full", 64'(ifa.out_valid), 64'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", 64'(ifa.in_ready), 64'd0);
    tick();
    check("mid_rst_out_valid", 64'(ifa.out_valid), 64'd0);
    check("mid_rst_chk", chk_a, 64'd0);
    check("mid_rst_cnt", 64'(cnt_a), 64'd0);
    reset = 1'b0; ifa.out_ready = 1'b1;
    #1;
    check("mid_rel_in_ready", 64'(ifa.in_ready), 64'd1);
    tick();
    check("mid_no_stale", 64'(ifa.out_valid), 64'd0);
    ifa.in_valid = 1'b1; ifa.in_data = {32'h12345678, 32'hFFFFFFFF}; tick();
    ifa.in_valid = 1'b0; tick();
    check("mid_next_valid", 64'(ifa.out_valid), 64'd1);
    check("mid_next_data", 64'(ifa.out_data), 64'h1234567A_00000001);
    check("mid_next_ovf", 64'(ifa.out_ovf), 64'd1);
    tick(); tick();
    check("mid_drained", 64'(qa.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
